// File: rtl/counter_sequencer_pkg.sv
// Shared state encoding and command op-codes for the counter sequencer.
package counter_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_PAUSE  = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_ABORT  = 2'd3;

endpackage

// File: rtl/counter_sequencer.sv
// Sequences an external up-counter: start/pause/resume/abort via a valid/ready
// command port, one-shot or auto-reload, with done pulse and saturating wrap count.
//
// state | meaning
// IDLE  | counter held cleared, waiting for START
// CLEAR | one-cycle counter clear before counting
// RUN   | counting towards limit_q
// PAUSE | count frozen, waiting for RESUME
// DONE  | one-shot finished, count held
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_reload,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [WRAPW-1:0] wrap_count,
    output logic [2:0]       state_dbg
);

    localparam logic [WRAPW-1:0] WRAP_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             reload_q;

    logic fire;
    logic match;
    logic do_start;
    logic do_pause;
    logic do_resume;
    logic do_abort;
    logic run_cmd;

    assign cmd_ready = (state != ST_CLEAR);
    assign fire      = cmd_valid & cmd_ready;
    // >= so a counter overrun externally still terminates the period
    assign match     = (cnt_value >= limit_q);

    assign do_start  = fire && (cmd_op == OP_START);
    assign do_pause  = fire && (cmd_op == OP_PAUSE)  && (state == ST_RUN);
    assign do_resume = fire && (cmd_op == OP_RESUME) && (state == ST_PAUSE);
    assign do_abort  = fire && (cmd_op == OP_ABORT)  && (state != ST_IDLE);
    assign run_cmd   = (state == ST_RUN) && (do_start || do_pause || do_abort);

    assign busy      = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_PAUSE);
    assign state_dbg = state;

    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state)
            ST_IDLE, ST_CLEAR: cnt_clr = 1'b1;
            ST_RUN: begin
                if (!run_cmd) begin
                    if (!match)        cnt_en  = 1'b1;
                    else if (reload_q) cnt_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            limit_q    <= '0;
            reload_q   <= 1'b0;
            done       <= 1'b0;
            wrap_count <= '0;
        end else begin
            done <= 1'b0;
            if (do_start) begin
                limit_q    <= cmd_limit;
                reload_q   <= cmd_reload;
                wrap_count <= '0;
                state      <= ST_CLEAR;
            end else if (do_abort) begin
                state <= ST_IDLE;
            end else if (do_pause) begin
                state <= ST_PAUSE;
            end else if (do_resume) begin
                state <= ST_RUN;
            end else begin
                case (state)
                    ST_CLEAR: state <= ST_RUN;
                    ST_RUN: begin
                        if (match) begin
                            if (reload_q) begin
                                if (wrap_count != WRAP_MAX)
                                    wrap_count <= wrap_count + WRAPW'(1);
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control block that sequences a WIDTH-bit up-counter datapath. It starts, pauses, resumes and aborts counting to a programmable terminal value through a valid/ready command port, in one-shot or auto-reload mode. It drives the counter's enable and clear, and monitors its count. It reports busy status, a done pulse and a saturating count of completed periods.

Parameters:
WIDTH, 4, counter datapath width in bits
WRAPW, 8, width of completed-period counter wrap_count

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted; fire = cmd_valid & cmd_ready
cmd_op  input  2  0=START, 1=PAUSE, 2=RESUME, 3=ABORT
cmd_limit  input  WIDTH  terminal value, sampled on START fire
cmd_reload  input  1  auto-reload mode, sampled on START fire
cnt_value  input  WIDTH  current counter value from datapath
cnt_en  output  1  counter increments on next edge
cnt_clr  output  1  counter goes to 0 on next edge (priority over cnt_en)
busy  output  1  state is CLEAR, RUN or PAUSE
done  output  1  one-cycle pulse, one-shot run completed
wrap_count  output  WRAPW  completed reload periods, saturating
state_dbg  output  3  current state encoding

Behaviour:
- Reset (sampled low at edge):
  - state=IDLE, limit_q=0, reload_q=0, done=0, wrap_count=0.
  - Outputs: cnt_en=0, cnt_clr=1, busy=0, cmd_ready=1.
- States:
  - IDLE: cnt_clr=1 continuously.
  - CLEAR: cnt_clr=1 for exactly one cycle; cmd_ready=0.
  - RUN: counting.
  - PAUSE: cnt_en=0, cnt_clr=0.
  - DONE: count held, cnt_en=0, cnt_clr=0.
- cmd_ready=1 in every state except CLEAR.
- match = (cnt_value >= limit_q). Using >= makes an externally overrun counter terminate.
- Transitions on command fire:
  - START, any state except CLEAR: latch limit/reload, clear wrap_count, go CLEAR. A START in RUN/PAUSE restarts.
  - PAUSE in RUN: go PAUSE. Otherwise ignored.
  - RESUME in PAUSE: go RUN. Otherwise ignored.
  - ABORT in CLEAR/RUN/PAUSE/DONE: go IDLE; no done pulse.
  - Ignored commands are still accepted (consumed).
- CLEAR -> RUN unconditionally after one cycle.
- RUN, no command fire:
  - !match: cnt_en=1.
  - match and reload_q=1: cnt_en=0, cnt_clr=1, wrap_count+1 (holds at 2^WRAPW-1), stay RUN. Period = limit+1 RUN cycles.
  - match and reload_q=0: cnt_en=0, go DONE; done=1 during the first DONE cycle only.
- Same-cycle PAUSE/ABORT/START fire in RUN:
  - cnt_en=0 and cnt_clr=0 that cycle, except ABORT and START, which take their target state's behaviour next cycle.
  - The command wins over match; a pending match is re-evaluated on RESUME.
- Latency: START fire at edge E0; cnt_clr high in the cycle after E0; count=0 after E1; count=k after edge E1+k. One-shot with limit L: done high in the cycle after edge E1+L+1.
- limit=0: one-shot finishes right after CLEAR. Reload gives a 1-cycle period, wrap_count +1 every RUN cycle.
- Reset mid-operation: immediate IDLE, all state lost, no done.

Decomposition:
- Package counter_sequencer_pkg:
  - state encoding: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4;
  - op-code constants: OP_START, OP_PAUSE, OP_RESUME, OP_ABORT.
- No sub-module. The FSM, the limit/reload registers and the saturating wrap_count are all in one module.
- Benches pair the block with an up-counter model that honours cnt_clr/cnt_en.

Test Plan:
- One-shot: START limit=5 reload=0 -> one cnt_clr cycle; count 0..5; done pulse for exactly 1 cycle; count holds 5; busy falls with done.
- Reload: START limit=3 reload=1, run 16 RUN cycles -> count pattern 0,1,2,3,0,... and wrap_count=4; done never asserts.
- Pause/resume: PAUSE fired when count=2, held 4 cycles -> count stays 2, cnt_en=0. RESUME -> count continues 3,4,5; done pulse.
- Abort/restart: ABORT at count=4 -> IDLE next edge, count 0 after following edge, no done. START limit=2 issued in RUN -> restart from 0, wrap_count cleared.
- Edges: limit=0 one-shot -> done 2 cycles after CLEAR. limit=0 reload for 300 cycles -> wrap_count saturates at 255. cmd_valid held during CLEAR -> not accepted until RUN.
- Reset mid-run: reset low for one edge at count=3, wrap_count=2 -> state IDLE, wrap_count=0, done=0, cnt_clr=1, cmd_ready=1.
